mpmc10_resp_fifo256_wb: RTL
===========================

Name: mpmc10_resp_fifo256_wb

Overview:
- Response-direction counterpart of the 256-bit write-request sync stage.
- Buffers wb_read_response256_t beats returning from the mpmc10 memory side toward a requesting channel.
- Decouples controller response timing from channel acceptance using a small first-word-fall-through FIFO with explicit pop.
- Sits between the mpmc10 read-data return path and the per-channel Wishbone response port.

Parameters:
- DEPTH, 4, number of response entries; power of two, 2..16.
- AWID, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- i  input  $bits(wb_read_response256_t)  incoming response; i.ack=1 means push request.
- pop  input  1  channel consumes head entry this cycle.
- o  output  $bits(wb_read_response256_t)  head entry; o.ack=1 only when FIFO non-empty.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- cnt  output  AWID+1  occupancy.
- ovf  output  1  sticky overflow flag.

Behaviour:
- One clock domain (clk); reset synchronous, active-high (rst). Both are fixed.
- Reset values: wptr=0, rptr=0, cnt=0, empty=1, full=0, ovf=0, o=all zeros (o.ack=0).
- Storage: DEPTH x $bits(wb_read_response256_t) register array; entries are not cleared on reset.
- Push occurs when i.ack=1 and (!full or pop). The whole struct is written at wptr, and wptr increments modulo DEPTH.
- Pop occurs when pop=1 and !empty. rptr increments modulo DEPTH. pop while empty is ignored, with no state change.
- cnt: +1 on push only, -1 on pop only, unchanged on push+pop or idle.
- Full with simultaneous push and pop: both occur; cnt stays DEPTH, full stays 1, no overflow.
- Empty with simultaneous push and pop: push occurs, pop ignored; cnt becomes 1.
- Overflow: i.ack=1 while full and pop=0 drops the beat and sets ovf=1. ovf clears only on rst.
- Output o is registered, first-word-fall-through. Beat pushed into an empty FIFO at edge N appears on o (o.ack=1) after edge N. Latency is 1 cycle.
- After a pop at edge N, o shows the next entry after edge N, or all zeros if the FIFO is now empty.
- Output ordering strictly equals push order; no reordering by cid/tid.
- empty, full and cnt are registered and consistent with o in the same cycle.
- Pointer wrap: pointers wrap from DEPTH-1 to 0. full/empty are derived from cnt, not from pointer comparison.
- Reset mid-operation: all queued entries are discarded and outputs return to reset values next cycle. i.ack and pop in the reset cycle are ignored.
- The block does not modify struct fields; data, cid, tid and err pass bit-exact.

Test Plan:
1. Reset then idle -> o=0, empty=1, full=0, cnt=0, ovf=0; pop=1 while empty leaves all unchanged.
2. Single beat: push dat=256'hA5..A5 with tid=3 at edge 1 -> after edge 1, o.ack=1, o.dat=A5..A5, o.tid=3, cnt=1. Pop at edge 3 -> o=0, empty=1.
3. Fill DEPTH=4 with dat=1,2,3,4, no pops -> full=1, cnt=4. A 5th push (dat=5) -> ovf=1, cnt=4. Draining yields 1,2,3,4 only.
4. Full with push dat=9 and pop in the same cycle -> cnt stays 4, ovf=0. Drain order is 2,3,4,9.
5. Continuous push+pop streaming for 20 beats (dat=0..19) -> cnt stays at 1 after the first beat; output sequence is 0..19 in order; pointers wrap at least 4 times.
6. Push 3 beats, assert rst for 1 cycle with i.ack=1 -> after reset cnt=0, empty=1, o.ack=0, and the next push appears as the sole head entry.

Source files
------------

// File: rtl/mpmc10_resp_fifo256_wb_if.sv
// mpmc10_resp_fifo256_wb_if: response beat type and FIFO port bundle between
// the mpmc10 read-data return path and a channel's Wishbone response port.
package mpmc10_resp_pkg;
    typedef struct packed {
        logic [3:0]   cid;
        logic [7:0]   tid;
        logic         ack;
        logic         err;
        logic [255:0] dat;
    } wb_read_response256_t;
endpackage

interface mpmc10_resp_fifo256_wb_if #(parameter int DEPTH = 4);
    import mpmc10_resp_pkg::*;
    localparam int AWID = $clog2(DEPTH);
    wb_read_response256_t i;
    wb_read_response256_t o;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [AWID:0]        cnt;
    logic                 ovf;
    modport master (output i, pop, input o, full, empty, cnt, ovf);
    modport slave  (input i, pop, output o, full, empty, cnt, ovf);
endinterface

// File: rtl/mpmc10_resp_fifo256_wb.sv
// mpmc10_resp_fifo256_wb: registered first-word-fall-through FIFO for 256-bit
// read responses, with explicit pop and sticky overflow.
module mpmc10_resp_fifo256_wb
    import mpmc10_resp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    mpmc10_resp_fifo256_wb_if.slave bus
);
    localparam int AWID = $clog2(DEPTH);

    wb_read_response256_t mem [DEPTH];
    wb_read_response256_t o_n;
    logic [AWID-1:0]      wptr, rptr, rptr_n;
    logic [AWID:0]        cnt_n;
    logic                 do_push, do_pop;

    // The next head may be the beat being written this edge (empty push, or
    // push+pop with one entry), so bypass the array in that case.
    always_comb begin
        do_pop  = bus.pop && !bus.empty;
        do_push = bus.i.ack && (!bus.full || bus.pop);
        rptr_n  = do_pop ? rptr + 1'b1 : rptr;
        cnt_n   = bus.cnt + {{AWID{1'b0}}, do_push} - {{AWID{1'b0}}, do_pop};
        o_n     = (cnt_n == '0) ? '0 : (do_push && rptr_n == wptr) ? bus.i : mem[rptr_n];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            bus.cnt   <= '0;
            bus.empty <= 1'b1;
            bus.full  <= 1'b0;
            bus.ovf   <= 1'b0;
            bus.o     <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            rptr      <= rptr_n;
            bus.cnt   <= cnt_n;
            bus.empty <= cnt_n == '0;
            bus.full  <= cnt_n == (AWID+1)'(DEPTH);
            bus.ovf   <= bus.ovf | (bus.i.ack && bus.full && !bus.pop);
            bus.o     <= o_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push)
            mem[wptr] <= bus.i;
    end
endmodule
